// File: rtl/arbl2_req_sched.sv
// Round-robin scheduler sharing the directory request channel between L2D slices.
// Winners are tagged with their slice index and buffered in a 2-entry queue.
module arbl2_req_sched #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        in_valid,
    output logic [NREQ-1:0]        in_retry,
    input  logic [NREQ*DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_retry,
    output logic [DATA_W-1:0]      out_data,
    output logic [SRC_W-1:0]       out_src
);
    logic [1:0]        count;
    logic              wr;
    logic              rd;
    logic [SRC_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] q_data [2];
    logic [SRC_W-1:0]  q_src  [2];

    logic              space;
    logic              found;
    logic              push;
    logic              pop;
    logic [SRC_W-1:0]  gnt;
    logic [SRC_W-1:0]  rr_next;
    logic [DATA_W-1:0] gnt_data;

    // space looks at registered count only, so out_retry never reaches in_retry
    assign space     = (count < 2'd2);
    assign push      = found && space && reset;
    assign pop       = out_valid && !out_retry;
    assign out_valid = (count != 2'd0);
    assign out_data  = q_data[rd];
    assign out_src   = q_src[rd];

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && in_valid[i] &&
                    i == (int'(rr_ptr) + k) % NREQ) begin
                    found = 1'b1;
                    gnt   = SRC_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == SRC_W'(i)) begin
                gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_retry = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (push && gnt == SRC_W'(i)) begin
                in_retry[i] = 1'b0;
            end
        end
    end

    assign rr_next = (gnt == SRC_W'(NREQ - 1)) ? '0 : gnt + SRC_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr     <= ~wr;
                rr_ptr <= rr_next;
            end
            if (pop) begin
                rd <= ~rd;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only read while out_valid=1
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr] <= gnt_data;
            q_src[wr]  <= gnt;
        end
    end

endmodule

// File: tb/tb_arbl2_req_sched.sv
// Bench for arbl2_req_sched: directed scenarios plus randomized traffic
// against a queue-based reference model, on a 2-slice and a 4-slice instance.
module tb_arbl2_req_sched;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]      v2, r2;
    logic [2*DW-1:0] d2;
    logic            ort2, ov2;
    logic [DW-1:0]   od2;
    logic [1:0]      os2;

    logic [3:0]      v4, r4;
    logic [4*DW-1:0] d4;
    logic            ort4, ov4;
    logic [DW-1:0]   od4;
    logic [1:0]      os4;

    arbl2_req_sched #(.NREQ(2), .DATA_W(DW), .SRC_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_retry(r2),
        .in_data(d2), .out_valid(ov2), .out_retry(ort2),
        .out_data(od2), .out_src(os2));

    arbl2_req_sched #(.NREQ(4), .DATA_W(DW), .SRC_W(2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_retry(r4),
        .in_data(d4), .out_valid(ov4), .out_retry(ort4),
        .out_data(od4), .out_src(os4));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: FIFO of accepted requests plus a rotating priority start
    logic [DW-1:0] q2d[$], q4d[$];
    int            q2s[$], q4s[$];
    int            rr2 = 0, rr4 = 0;
    int            g2, g4;
    logic [3:0]    e2, e4;

    function automatic int mgrant(int n, logic [3:0] v, int rr, int sz);
        if (sz >= 2) return -1;
        for (int k = 0; k < n; k++)
            if (v[(rr + k) % n]) return (rr + k) % n;
        return -1;
    endfunction

    function automatic logic [3:0] mretry(int n, logic [3:0] v, int rr,
                                          int sz, logic rst);
        logic [3:0] m;
        int g;
        m = 4'((1 << n) - 1);
        if (!rst) return m;
        g = mgrant(n, v, rr, sz);
        if (g < 0) return m;
        return m & ~(4'd1 << g);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q2d.delete(); q2s.delete(); q4d.delete(); q4s.delete();
            rr2 = 0; rr4 = 0;
        end else begin
            g2 = mgrant(2, {2'b00, v2}, rr2, q2d.size());
            g4 = mgrant(4, v4, rr4, q4d.size());
            if (q2d.size() != 0 && !ort2) begin
                void'(q2d.pop_front()); void'(q2s.pop_front());
            end
            if (q4d.size() != 0 && !ort4) begin
                void'(q4d.pop_front()); void'(q4s.pop_front());
            end
            if (g2 >= 0) begin
                q2d.push_back(d2[g2*DW +: DW]); q2s.push_back(g2);
                rr2 = (g2 + 1) % 2;
            end
            if (g4 >= 0) begin
                q4d.push_back(d4[g4*DW +: DW]); q4s.push_back(g4);
                rr4 = (g4 + 1) % 4;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        v2 = 2'b11; v4 = 4'hf; ort2 = 1'b0; ort4 = 1'b0;
        d2 = '0; d4 = '0;
        #12;
        n_cmp++;
        if (r2 !== 2'b11) begin
            n_fail++; $display("FAIL reset_retry2 got %b want 11", r2);
        end
        n_cmp++;
        if (r4 !== 4'hf) begin
            n_fail++; $display("FAIL reset_retry4 got %b want 1111", r4);
        end
        n_cmp++;
        if (ov2 !== 1'b0 || ov4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b%b want 00", ov2, ov4);
        end
        @(negedge clk);
        reset = 1'b1; v2 = '0; v4 = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        v2 = 2'b01; d2[DW-1:0] = 64'hA5;
        #1;
        n_cmp++;
        if (r2 !== 2'b10) begin
            n_fail++; $display("FAIL single_retry got %b want 10", r2);
        end
        @(negedge clk);
        v2 = 2'b11; d2 = {64'h11, 64'h22};
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || od2 !== 64'hA5 || os2 !== 2'd0) begin
            n_fail++;
            $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=a5 s=0",
                     ov2, od2, os2);
        end
        n_cmp++;
        if (r2 !== 2'b01) begin
            n_fail++; $display("FAIL single_rr got %b want 01", r2);
        end
        @(negedge clk);
        v2 = '0;
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || od2 !== 64'h11 || os2 !== 2'd1) begin
            n_fail++;
            $display("FAIL single_out2 got v=%b d=%h s=%0d want v=1 d=11 s=1",
                     ov2, od2, os2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov2 !== 1'b0) begin
            n_fail++; $display("FAIL single_drain got %b want 0", ov2);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            v2 = (c < 4) ? 2'b11 : 2'b00;
            d2 = {64'hB1, 64'hA0};
            #1;
            if (c < 4) begin
                want = (c % 2 == 0) ? 2'b10 : 2'b01;
                n_cmp++;
                if (r2 !== want) begin
                    n_fail++;
                    $display("FAIL cont_retry c=%0d got %b want %b", c, r2, want);
                end
            end
            if (c >= 1) begin
                n_cmp++;
                if (ov2 !== 1'b1 || os2 !== 2'((c - 1) % 2) ||
                    od2 !== (((c - 1) % 2 == 0) ? 64'hA0 : 64'hB1)) begin
                    n_fail++;
                    $display("FAIL cont_out c=%0d got v=%b s=%0d d=%h",
                             c, ov2, os2, od2);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int grants;
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ort2 = 1'b1; v2 = 2'b11; d2 = {64'hC1, 64'hC0};
            #1;
            if (r2 !== 2'b11) grants++;
        end
        n_cmp++;
        if (grants != 2) begin
            n_fail++; $display("FAIL bp_grants got %0d want 2", grants);
        end
        @(negedge clk);
        ort2 = 1'b0;
        #1;
        n_cmp++;
        if (r2 !== 2'b11 || ov2 !== 1'b1 || os2 !== 2'd0 || od2 !== 64'hC0) begin
            n_fail++;
            $display("FAIL bp_full got r=%b v=%b s=%0d want r=11 v=1 s=0",
                     r2, ov2, os2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (r2 !== 2'b10 || os2 !== 2'd1 || od2 !== 64'hC1) begin
            n_fail++;
            $display("FAIL bp_regrant got r=%b s=%0d want r=10 s=1", r2, os2);
        end
        @(negedge clk);
        v2 = '0;
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || os2 !== 2'd0 || od2 !== 64'hC0) begin
            n_fail++;
            $display("FAIL bp_tail got v=%b s=%0d d=%h want v=1 s=0 d=c0",
                     ov2, os2, od2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov2 !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty got %b want 0", ov2);
        end
    endtask

    task automatic test_push_pop();
        @(negedge clk);
        v2 = 2'b01; d2 = {64'hD1, 64'hD0};
        #1;
        n_cmp++;
        if (r2 !== 2'b10) begin
            n_fail++; $display("FAIL pp_first got %b want 10", r2);
        end
        @(negedge clk);
        v2 = 2'b10;
        #1;
        n_cmp++;
        if (r2 !== 2'b01 || od2 !== 64'hD0 || os2 !== 2'd0) begin
            n_fail++;
            $display("FAIL pp_both got r=%b d=%h s=%0d want r=01 d=d0 s=0",
                     r2, od2, os2);
        end
        @(negedge clk);
        v2 = '0;
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || od2 !== 64'hD1 || os2 !== 2'd1) begin
            n_fail++;
            $display("FAIL pp_adv got v=%b d=%h s=%0d want v=1 d=d1 s=1",
                     ov2, od2, os2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov2 !== 1'b0) begin
            n_fail++; $display("FAIL pp_nodup got %b want 0", ov2);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ort2 = 1'b1; v2 = 2'b11; d2 = {64'hE1, 64'hE0};
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || r2 !== 2'b11) begin
            n_fail++; $display("FAIL rm_full got v=%b r=%b want v=1 r=11", ov2, r2);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (ov2 !== 1'b0 || r2 !== 2'b11 || r4 !== 4'hf) begin
            n_fail++;
            $display("FAIL rm_async got v=%b r=%b r4=%b want 0/11/1111",
                     ov2, r2, r4);
        end
        @(negedge clk);
        reset = 1'b1; ort2 = 1'b0; v2 = 2'b10;
        #1;
        n_cmp++;
        if (r2 !== 2'b01) begin
            n_fail++; $display("FAIL rm_grant got %b want 01", r2);
        end
        @(negedge clk);
        v2 = '0;
        #1;
        n_cmp++;
        if (ov2 !== 1'b1 || os2 !== 2'd1 || od2 !== 64'hE1) begin
            n_fail++;
            $display("FAIL rm_out got v=%b s=%0d d=%h want v=1 s=1 d=e1",
                     ov2, os2, od2);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap4();
        @(negedge clk);
        v4 = 4'b1000; d4 = '0; d4[3*DW +: DW] = 64'h33;
        #1;
        n_cmp++;
        if (r4 !== 4'b0111) begin
            n_fail++; $display("FAIL w4_first got %b want 0111", r4);
        end
        @(negedge clk);
        v4 = 4'b1001; d4[DW-1:0] = 64'h30;
        #1;
        n_cmp++;
        if (r4 !== 4'b1110 || os4 !== 2'd3 || od4 !== 64'h33) begin
            n_fail++;
            $display("FAIL w4_wrap got r=%b s=%0d d=%h want r=1110 s=3 d=33",
                     r4, os4, od4);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (r4 !== 4'b0111 || os4 !== 2'd0 || od4 !== 64'h30) begin
            n_fail++;
            $display("FAIL w4_next got r=%b s=%0d d=%h want r=0111 s=0 d=30",
                     r4, os4, od4);
        end
        @(negedge clk);
        v4 = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ov4 !== 1'b0) begin
            n_fail++; $display("FAIL w4_drain got %b want 0", ov4);
        end
    endtask

    task automatic test_random();
        logic [3:0] last2, last4;
        last2 = '0; last4 = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            // A retried requester holds valid and payload until it transfers
            for (int i = 0; i < 2; i++)
                if (!v2[i] || !last2[i]) begin
                    v2[i] = ($urandom_range(0, 2) != 0);
                    d2[i*DW +: DW] = {$urandom, $urandom};
                end
            for (int i = 0; i < 4; i++)
                if (!v4[i] || !last4[i]) begin
                    v4[i] = ($urandom_range(0, 2) == 0);
                    d4[i*DW +: DW] = {$urandom, $urandom};
                end
            ort2 = ($urandom_range(0, 3) == 0);
            ort4 = ($urandom_range(0, 2) == 0);
            #1;
            e2 = mretry(2, {2'b00, v2}, rr2, q2d.size(), reset);
            e4 = mretry(4, v4, rr4, q4d.size(), reset);
            last2 = e2; last4 = e4;
            n_cmp++;
            if (r2 !== e2[1:0] || r4 !== e4) begin
                n_fail++;
                $display("FAIL rnd_retry c=%0d got %b/%b want %b/%b",
                         c, r2, r4, e2[1:0], e4);
            end
            n_cmp++;
            if (ov2 !== (q2d.size() != 0) || ov4 !== (q4d.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid c=%0d got %b/%b want %0d/%0d",
                         c, ov2, ov4, q2d.size(), q4d.size());
            end
            if (q2d.size() != 0) begin
                n_cmp++;
                if (od2 !== q2d[0] || os2 !== 2'(q2s[0])) begin
                    n_fail++;
                    $display("FAIL rnd_head2 c=%0d got %h/%0d want %h/%0d",
                             c, od2, os2, q2d[0], q2s[0]);
                end
            end
            if (q4d.size() != 0) begin
                n_cmp++;
                if (od4 !== q4d[0] || os4 !== 2'(q4s[0])) begin
                    n_fail++;
                    $display("FAIL rnd_head4 c=%0d got %h/%0d want %h/%0d",
                             c, od4, os4, q4d[0], q4s[0]);
                end
            end
        end
        @(negedge clk);
        v2 = '0; v4 = '0; ort2 = 1'b0; ort4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_push_pop();
        test_reset_mid();
        test_wrap4();
        test_random();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
